// File: rtl/mode_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot boundary modes.
// Q, TC and DONE are all registered; nothing combinational reaches the outputs.
module mode_counter #(
  parameter int N   = 16,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic [1:0]   mode,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] limit,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         done
);

  typedef enum logic [1:0] {
    M_WRAP  = 2'b00,
    M_SAT   = 2'b01,
    M_ONE   = 2'b10,
    M_RSVD  = 2'b11
  } mode_e;

  logic         tick;
  logic [N-1:0] q_n;
  logic         tc_n;
  logic         done_n;
  logic         at_bnd;
  mode_e        m;

  generate
    if (DIV == 1) begin : g_nopre
      assign tick = en;
    end else begin : g_pre
      localparam int PW = $clog2(DIV);
      logic [PW-1:0] pre;
      logic          pre_last;
      assign pre_last = (pre == PW'(DIV - 1));
      assign tick     = en && pre_last;
      always_ff @(posedge clk) begin
        if (reset || load)
          pre <= '0;
        else if (en)
          pre <= pre_last ? '0 : pre + PW'(1);
      end
    end
  endgenerate

  assign m      = mode_e'(mode);
  assign at_bnd = dir ? (q >= limit) : (q == '0);

  always_comb begin
    q_n    = q;
    tc_n   = 1'b0;
    done_n = done;
    if (load) begin
      q_n    = load_val;
      done_n = 1'b0;
    end else if (tick && !(m == M_ONE && done)) begin
      if (!at_bnd) begin
        q_n = dir ? q + N'(1) : q - N'(1);
      end else begin
        tc_n = 1'b1;
        case (m)
          M_SAT, M_ONE: q_n = dir ? limit : '0;  // clamps an over-limit load
          default:      q_n = dir ? '0 : limit;   // wrap and reserved
        endcase
        if (m == M_ONE)
          done_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      tc   <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_n;
      tc   <= tc_n;
      done <= done_n;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Directed-vector bench for mode_counter: N=4 with DIV=1 and DIV=3 instances
// driven from the same inputs.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       reset, en, dir, load;
  logic [1:0] mode;
  logic [3:0] load_val, limit;
  logic [3:0] q1, q3;
  logic       tc1, tc3, done1, done3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mode_counter #(.N(4), .DIV(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .q(q1), .tc(tc1), .done(done1)
  );

  mode_counter #(.N(4), .DIV(3)) u3 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .limit(limit), .q(q3), .tc(tc3), .done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input int eq, input int etc, input int edone);
    chk({tag, ".q"},    32'(q1),    32'(eq));
    chk({tag, ".tc"},   32'(tc1),   32'(etc));
    chk({tag, ".done"}, 32'(done1), 32'(edone));
  endtask

  int q3exp [7] = '{0, 0, 0, 1, 1, 1, 2};
  logic en3seq [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    reset = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b1; mode = 2'b00;
    load_val = 4'd7; limit = 4'd9;
    step();
    chk1("reset", 0, 0, 0);
    chk("reset.q3", 32'(q3), 32'd0);

    // wrap up count 0..9,0,1
    reset = 1'b0; load = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      chk1($sformatf("wrap%0d", i), i % 10, (i == 10) ? 1 : 0, 0);
    end

    // en low: hold, no tc
    en = 1'b0;
    step();
    chk1("enlow", 1, 0, 0);

    // saturate down from 2
    en = 1'b1; mode = 2'b01; dir = 1'b0; load_val = 4'd2; load = 1'b1;
    step(); chk1("sat.ld", 2, 0, 0);
    load = 1'b0;
    step(); chk1("sat1", 1, 0, 0);
    step(); chk1("sat0", 0, 0, 0);
    step(); chk1("satb1", 0, 1, 0);
    step(); chk1("satb2", 0, 1, 0);

    // one-shot up from 3, limit 5
    limit = 4'd5; mode = 2'b10; dir = 1'b1; load_val = 4'd3; load = 1'b1;
    step(); chk1("os.ld", 3, 0, 0);
    load = 1'b0;
    step(); chk1("os4", 4, 0, 0);
    step(); chk1("os5", 5, 0, 0);
    step(); chk1("osb", 5, 1, 1);
    step(); chk1("osign1", 5, 0, 1);
    step(); chk1("osign2", 5, 0, 1);

    // leaving one-shot keeps done but unblocks ticks
    mode = 2'b00;
    step(); chk1("os.wrap", 0, 1, 1);
    step(); chk1("os.cnt", 1, 0, 1);
    mode = 2'b10;
    step(); chk1("os.blk", 1, 0, 1);
    load_val = 4'd0; load = 1'b1;
    step(); chk1("os.ld0", 0, 0, 0);
    load = 1'b0;
    step(); chk1("os.rst", 1, 0, 0);

    // reset beats load; load beats a boundary tick
    mode = 2'b00; limit = 4'd9; load_val = 4'd7; load = 1'b1;
    step(); chk1("pri.ld7", 7, 0, 0);
    reset = 1'b1;
    step(); chk1("pri.rst", 0, 0, 0);
    reset = 1'b0; load_val = 4'd9;
    step(); chk1("pri.ld9", 9, 0, 0);
    step(); chk1("pri.ldtick", 9, 0, 0);
    load = 1'b0;
    step(); chk1("pri.wrap", 0, 1, 0);

    // over-limit load
    load_val = 4'd13; load = 1'b1;
    step(); chk1("ovr.ld", 13, 0, 0);
    load = 1'b0;
    step(); chk1("ovr.wrap", 0, 1, 0);
    mode = 2'b01; load = 1'b1;
    step(); chk1("ovr.ld2", 13, 0, 0);
    load = 1'b0;
    step(); chk1("ovr.sat", 9, 1, 0);

    // limit 0: every tick is a boundary
    limit = 4'd0; mode = 2'b00; load_val = 4'd0; load = 1'b1;
    step(); chk1("l0.ld", 0, 0, 0);
    load = 1'b0;
    step(); chk1("l0.up", 0, 1, 0);
    dir = 1'b0;
    step(); chk1("l0.dn", 0, 1, 0);
    mode = 2'b11; dir = 1'b1;
    step(); chk1("l0.rsvd", 0, 1, 0);

    // DIV=3 prescaler on u3
    limit = 4'd15; mode = 2'b00; dir = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = en3seq[i];
      step();
      chk($sformatf("div3.q%0d", i), 32'(q3), 32'(q3exp[i]));
    end
    // partial prescale progress discarded by reset
    en = 1'b1;
    step();
    reset = 1'b1;
    step(); chk("div3.rst", 32'(q3), 32'd0);
    reset = 1'b0;
    step(); chk("div3.r1", 32'(q3), 32'd0);
    step(); chk("div3.r2", 32'(q3), 32'd0);
    step(); chk("div3.r3", 32'(q3), 32'd1);
    chk("div3.tc", 32'(tc3), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter N, default 16, counter width in bits (N >= 2).
REQ-002 Parameter DIV, default 1, prescale ratio: one count step per DIV enabled cycles (DIV >= 1).
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 EN  input  1  count enable; prescaler advances only when high.
REQ-007 DIR  input  1  1 = count up, 0 = count down.
REQ-008 MODE  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-009 LOAD  input  1  synchronous load of LOAD_VAL into Q.
REQ-010 LOAD_VAL  input  N  value loaded on LOAD.
REQ-011 LIMIT  input  N  upper bound; legal count range 0..LIMIT.
REQ-012 Q  output  N  registered count value.
REQ-013 TC  output  1  registered one-cycle terminal-count pulse.
REQ-014 DONE  output  1  sticky one-shot completion flag.

Function
REQ-015 Prescaler: internal counter PRE, 0..DIV-1, increments on each EN-high cycle; tick asserts when EN=1 and PRE=DIV-1, and PRE returns to 0 on that cycle.
REQ-016 DIV=1: tick on every EN-high cycle; no prescale state is required.
REQ-017 EN=0: Q, PRE and DONE SHALL hold; TC SHALL be 0 the following cycle.
REQ-018 Priority per cycle: RESET > LOAD > tick.
REQ-019 LOAD: Q <= LOAD_VAL, PRE <= 0, DONE <= 0, TC <= 0, regardless of EN; LOAD_VAL > LIMIT is loaded unchanged.
REQ-020 Boundary: up-boundary is Q >= LIMIT; down-boundary is Q == 0.
REQ-021 Tick, not at boundary: Q <= Q+1 (DIR=1) or Q-1 (DIR=0); TC <= 0.
REQ-022 Tick at boundary, wrap: up Q <= 0, down Q <= LIMIT; TC <= 1.
REQ-023 Tick at boundary, saturate: Q holds (up with Q > LIMIT: Q <= LIMIT); TC <= 1 on every boundary tick.
REQ-024 Tick at boundary, one-shot, DONE=0: Q holds (clamped to LIMIT as REQ-023); TC <= 1; DONE <= 1.
REQ-025 One-shot with DONE=1: ticks SHALL be ignored (Q holds, TC=0) until LOAD or RESET.
REQ-026 TC is high for exactly the one cycle following a boundary tick; never high two cycles in a row unless boundary ticks occur on consecutive cycles.
REQ-027 DIR, MODE, LIMIT changes take effect on the next tick with no pipeline delay; a MODE change away from one-shot does not clear DONE, and DONE=1 blocks ticks only in one-shot mode.
REQ-028 LIMIT=0: every tick is a boundary tick; Q stays 0 in all modes.
REQ-029 Arithmetic is modulo 2^N internally, but Q SHALL never leave 0..max(LIMIT, loaded value).
REQ-030 Latency: Q and TC update one cycle after the tick cycle; no combinational path from inputs to outputs.

Reset
REQ-031 RESET=1 at a rising edge: Q=0, PRE=0, TC=0, DONE=0 next cycle, overriding LOAD and EN.
REQ-032 RESET asserted mid-count or mid-prescale SHALL discard all progress; counting resumes from Q=0, PRE=0 on the first cycle after RESET deasserts.

Verification (N=4, DIV=1 unless stated)
REQ-033 LIMIT=9, MODE=00, DIR=1, EN=1 from reset -> Q 0..9,0,1; TC high only in the cycle Q returns to 0.
REQ-034 LIMIT=9, MODE=01, DIR=0, LOAD_VAL=2 -> Q 2,1,0,0,0; TC high every cycle Q held at 0.
REQ-035 LIMIT=5, MODE=10, DIR=1, load 3 -> Q 3,4,5,5; single TC, DONE=1 sticky; further EN ignored; LOAD 0 clears DONE and counting restarts.
REQ-036 DIV=3, LIMIT=15, EN toggled 1,0,1,1,1,1,1 -> Q steps only on 3rd and 6th EN-high cycles; EN-low cycles do not advance PRE.
REQ-037 RESET and LOAD same cycle at Q=7 -> Q=0, DONE=0; LOAD and tick same cycle -> Q=LOAD_VAL, no increment, TC=0.
REQ-038 LIMIT=9, load 13, DIR=1, MODE=00 -> next tick Q=0 with TC; MODE=01 -> Q=9 with TC.
